// File: rtl/ctrl_fsm_mc_wait.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback sequencing with memory wait states.
// Latency: outputs are decoded from the registered state; one state per cycle, memory states stretch until ready.
// Backpressure: imem_req/dmem_req are held until ready; a wait longer than WAIT_MAX traps. Define CTRL_FSM_JAL_EN for JAL.
module ctrl_fsm_mc_wait #(
    parameter logic [6:0] OP_R     = 7'b0110011,
    parameter logic [6:0] OP_I     = 7'b0010011,
    parameter logic [6:0] OP_LD    = 7'b0000011,
    parameter logic [6:0] OP_S     = 7'b0100011,
    parameter logic [6:0] OP_LUI   = 7'b0110111,
    parameter logic [6:0] OP_B     = 7'b1100011,
    parameter int         WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_write,
    output logic        load_ir,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        load_reg_a,
    output logic        load_reg_b,
    output logic        load_alu_out,
    output logic        load_mdr,
    output logic        write_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  alu_funct,
    output logic [1:0]  branch_op,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state_o
);

    localparam int              CW        = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]   WAIT_LIM  = CW'(WAIT_MAX);
    localparam logic [6:0]      OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH        = 4'd0,
        S_FETCH_LATCH  = 4'd1,
        S_DECODE       = 4'd2,
        S_EXEC_ADDR    = 4'd3,
        S_EXEC_R       = 4'd4,
        S_EXEC_BR      = 4'd5,
        S_MEM_RD       = 4'd6,
        S_MEM_RD_LATCH = 4'd7,
        S_MEM_WR       = 4'd8,
        S_WB_ALU       = 4'd9,
        S_WB_MEM       = 4'd10,
        S_WB_LUI       = 4'd11,
        S_TRAP         = 4'd12,
        S_EXEC_JAL     = 4'd13
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]      trap_cause_q, trap_cause_d;
    logic [1:0]      branch_op_q, branch_op_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       in_wait;
    logic       rdy_sel;
    logic       unused_ir_bits;

    assign opcode         = instruction[6:0];
    assign funct3         = instruction[14:12];
    assign funct7         = instruction[31:25];
    assign unused_ir_bits = ^{instruction[24:15], instruction[11:7]};

    // The handshake that matters depends on which memory the current state is waiting on
    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign rdy_sel = (state_q == S_FETCH) ? imem_ready : dmem_ready;

    // State, wait counter, trap cause and latched branch condition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            trap_cause_q <= 2'b00;
            branch_op_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
            branch_op_q  <= branch_op_d;
        end
    end

    // Next-state logic, including the memory timeout and illegal-opcode traps
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        trap_cause_d = trap_cause_q;
        branch_op_d  = branch_op_q;
        case (state_q)
            S_FETCH:        if (imem_ready) state_d = S_FETCH_LATCH;
            S_FETCH_LATCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_R && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
                    state_d = S_EXEC_R;
                end else if (opcode == OP_I || opcode == OP_LD || opcode == OP_S) begin
                    state_d = S_EXEC_ADDR;
                end else if (opcode == OP_LUI) begin
                    state_d = S_WB_LUI;
                end else if (opcode == OP_B && funct3[1] == 1'b0 && funct3 != 3'b010
                             && funct3 != 3'b110) begin
                    // 000/001/100/101 map onto eq/ne/lt/ge
                    state_d     = S_EXEC_BR;
                    branch_op_d = {funct3[2], funct3[0]};
`ifdef CTRL_FSM_JAL_EN
                end else if (opcode == OP_JAL) begin
                    state_d = S_EXEC_JAL;
`endif
                end else begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b01;
                end
            end
            S_EXEC_ADDR: begin
                if (opcode == OP_S)       state_d = S_MEM_WR;
                else if (opcode == OP_LD) state_d = S_MEM_RD;
                else                      state_d = S_WB_ALU;
            end
            S_EXEC_R:       state_d = S_WB_ALU;
            S_EXEC_BR:      state_d = S_FETCH;
            S_MEM_RD:       if (dmem_ready) state_d = S_MEM_RD_LATCH;
            S_MEM_RD_LATCH: state_d = S_WB_MEM;
            S_MEM_WR:       if (dmem_ready) state_d = S_FETCH;
            S_WB_ALU:       state_d = S_FETCH;
            S_WB_MEM:       state_d = S_FETCH;
            S_WB_LUI:       state_d = S_FETCH;
            S_TRAP:         state_d = S_TRAP;
`ifdef CTRL_FSM_JAL_EN
            S_EXEC_JAL:     state_d = S_FETCH;
`endif
            default: begin
                state_d      = S_TRAP;
                trap_cause_d = 2'b01;
            end
        endcase
        // A ready arriving in the last allowed cycle has already moved the state above
        if (in_wait && !rdy_sel) begin
            if (wait_cnt_q == WAIT_LIM) begin
                state_d      = S_TRAP;
                trap_cause_d = 2'b10;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
        if (state_d != state_q) wait_cnt_d = '0;
    end

    // Moore output decode from the registered state
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_write    = 1'b0;
        load_ir       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        load_reg_a    = 1'b0;
        load_reg_b    = 1'b0;
        load_alu_out  = 1'b0;
        load_mdr      = 1'b0;
        write_reg     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        mem_to_reg    = 2'b00;
        alu_funct     = 3'b000;
        branch_op     = 2'b00;
        trap          = 1'b0;
        trap_cause    = trap_cause_q;
        state_o       = state_q;
        case (state_q)
            S_FETCH:        imem_req = 1'b1;
            S_FETCH_LATCH: begin
                load_ir   = 1'b1;
                pc_write  = 1'b1;
                alu_funct = 3'b001;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                load_reg_a   = 1'b1;
                load_reg_b   = 1'b1;
                load_alu_out = 1'b1;
                alu_funct    = 3'b001;
                alu_src_b    = 2'b11;
            end
            S_EXEC_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_funct    = 3'b001;
                load_alu_out = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a    = 1'b1;
                load_alu_out = 1'b1;
                alu_funct    = instruction[30] ? 3'b010 : 3'b001;
            end
            S_EXEC_BR: begin
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                alu_src_a     = 1'b1;
                alu_funct     = 3'b010;
                branch_op     = branch_op_q;
            end
            S_MEM_RD:       dmem_req = 1'b1;
            S_MEM_RD_LATCH: load_mdr = 1'b1;
            S_MEM_WR: begin
                dmem_req   = 1'b1;
                dmem_write = 1'b1;
            end
            S_WB_ALU: write_reg = 1'b1;
            S_WB_MEM: begin
                write_reg  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_WB_LUI: begin
                write_reg  = 1'b1;
                mem_to_reg = 2'b10;
            end
            S_TRAP:   trap = 1'b1;
`ifdef CTRL_FSM_JAL_EN
            S_EXEC_JAL: begin
                write_reg  = 1'b1;
                mem_to_reg = 2'b11;
                pc_write   = 1'b1;
                pc_src     = 2'b10;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm_mc_wait.sv
// Bench for ctrl_fsm_mc_wait: builds an expected per-cycle trace from instruction semantics and ready delays.
// Latency: one trace entry per clock; inputs change on the falling edge, outputs checked just before.
// Backpressure: ready delays are chosen per memory phase, including timeouts and a reset during a store wait.
module tb_ctrl_fsm_mc_wait;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_write, load_ir, pc_write, pc_write_cond;
    logic        load_reg_a, load_reg_b, load_alu_out, load_mdr, write_reg, alu_src_a, trap;
    logic [1:0]  alu_src_b, pc_src, mem_to_reg, branch_op, trap_cause;
    logic [2:0]  alu_funct;
    logic [3:0]  state_o;

    always #5 clk = ~clk;

    ctrl_fsm_mc_wait #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_write(dmem_write),
        .load_ir(load_ir), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .load_reg_a(load_reg_a), .load_reg_b(load_reg_b), .load_alu_out(load_alu_out),
        .load_mdr(load_mdr), .write_reg(write_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
        .alu_funct(alu_funct), .branch_op(branch_op), .trap(trap),
        .trap_cause(trap_cause), .state_o(state_o)
    );

    typedef struct {
        logic [3:0]  st;
        logic        im;
        logic        dm;
        logic        rs;
        logic [31:0] ins;
        logic [1:0]  cause;
    } step_t;

    step_t q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic void push(input logic [3:0] st, input logic im, input logic dm,
                                 input logic rs, input logic [31:0] ins, input logic [1:0] cause);
        step_t s;
        s.st = st; s.im = im; s.dm = dm; s.rs = rs; s.ins = ins; s.cause = cause;
        q.push_back(s);
    endfunction

    // Cycle in which only one ready line matters; the other one is noise
    function automatic void push_wait(input logic [3:0] st, input logic rdy, input logic [31:0] ins);
        if (st == 4'd0) push(st, rdy, 1'($urandom), 1'b0, ins, 2'b00);
        else            push(st, 1'($urandom), rdy, 1'b0, ins, 2'b00);
    endfunction

    function automatic void push_any(input logic [3:0] st, input logic [31:0] ins);
        push(st, 1'($urandom), 1'($urandom), 1'b0, ins, 2'b00);
    endfunction

    // Trap is left only via reset, applied in the last trap cycle
    function automatic void push_trap(input logic [1:0] cause, input logic [31:0] ins);
        for (int k = 0; k < 3; k++) push(4'd12, 1'($urandom), 1'($urandom), k == 2, ins, cause);
    endfunction

    // A request may go unanswered for WAIT_MAX+1 cycles in total before the trap
    function automatic bit wait_phase(input logic [3:0] st, input int delay, input logic [31:0] ins);
        if (delay > WAIT_MAX) begin
            for (int k = 0; k <= WAIT_MAX; k++) push_wait(st, 1'b0, ins);
            push_trap(2'b10, ins);
            return 1'b1;
        end
        for (int k = 0; k < delay; k++) push_wait(st, 1'b0, ins);
        push_wait(st, 1'b1, ins);
        return 1'b0;
    endfunction

    function automatic void transaction(input logic [31:0] ins, input int di, input int dd, input bit abort);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        if (wait_phase(4'd0, di, ins)) return;
        push_any(4'd1, ins);
        push_any(4'd2, ins);
        if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
            push_any(4'd4, ins); push_any(4'd9, ins);
        end else if (op == 7'h13) begin
            push_any(4'd3, ins); push_any(4'd9, ins);
        end else if (op == 7'h03) begin
            push_any(4'd3, ins);
            if (wait_phase(4'd6, dd, ins)) return;
            push_any(4'd7, ins); push_any(4'd10, ins);
        end else if (op == 7'h23) begin
            push_any(4'd3, ins);
            if (abort) begin
                for (int k = 0; k < dd; k++) push_wait(4'd8, 1'b0, ins);
                push(4'd8, 1'($urandom), 1'b0, 1'b1, ins, 2'b00);
            end else begin
                void'(wait_phase(4'd8, dd, ins));
            end
        end else if (op == 7'h37) begin
            push_any(4'd11, ins);
        end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)) begin
            push_any(4'd5, ins);
`ifdef CTRL_FSM_JAL_EN
        end else if (op == 7'h6F) begin
            push_any(4'd13, ins);
`endif
        end else begin
            push_trap(2'b01, ins);
        end
    endfunction

    // Expected control word per state, in the order of the observed-bus packing below
    function automatic logic [25:0] exp_out(input logic [3:0] st, input logic [31:0] ins, input logic [1:0] cause);
        logic ir, pw, pwc, ra, rb, ao, mdr, wr, sa, imr, dmr, dmw, tr;
        logic [1:0] sb, ps, m2r, bop, tc;
        logic [2:0] af;
        {ir, pw, pwc, ra, rb, ao, mdr, wr, sa, imr, dmr, dmw, tr} = '0;
        {sb, ps, m2r, bop, tc, af} = '0;
        case (st)
            4'd0:  imr = 1;
            4'd1:  begin ir = 1; pw = 1; af = 3'b001; sb = 2'b01; end
            4'd2:  begin ra = 1; rb = 1; ao = 1; af = 3'b001; sb = 2'b11; end
            4'd3:  begin sa = 1; sb = 2'b10; af = 3'b001; ao = 1; end
            4'd4:  begin sa = 1; ao = 1; af = (ins[31:25] == 7'h20) ? 3'b010 : 3'b001; end
            4'd5: begin
                pwc = 1; ps = 2'b01; sa = 1; af = 3'b010;
                case (ins[14:12])
                    3'd0: bop = 2'b00;
                    3'd1: bop = 2'b01;
                    3'd4: bop = 2'b10;
                    default: bop = 2'b11;
                endcase
            end
            4'd6:  dmr = 1;
            4'd7:  mdr = 1;
            4'd8:  begin dmr = 1; dmw = 1; end
            4'd9:  wr = 1;
            4'd10: begin wr = 1; m2r = 2'b01; end
            4'd11: begin wr = 1; m2r = 2'b10; end
            4'd12: begin tr = 1; tc = cause; end
            4'd13: begin wr = 1; m2r = 2'b11; pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {imr, dmr, dmw, ir, pw, pwc, ra, rb, ao, mdr, wr, sa, sb, ps, m2r, af, bop, tr, tc};
    endfunction

    logic [25:0] obs, expv;
    assign obs = {imem_req, dmem_req, dmem_write, load_ir, pc_write, pc_write_cond, load_reg_a,
                  load_reg_b, load_alu_out, load_mdr, write_reg, alu_src_a, alu_src_b, pc_src,
                  mem_to_reg, alu_funct, branch_op, trap, trap_cause};

    initial begin
        logic [31:0] ins;
        int          kind, di, dd, r;
        bit          abort;
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; instruction = 32'h0;

        // Directed cases first
        transaction(32'h002081B3, 0, 0, 1'b0);          // ADD
        transaction(32'h0080A283, 0, 3, 1'b0);          // LW, three wait cycles
        transaction(32'h0020D063, 1, 0, 1'b0);          // BGE
        transaction(32'h402081B3, 15, 0, 1'b0);         // SUB, ready in the last allowed cycle
        transaction(32'h002081B3, 16, 0, 1'b0);         // fetch timeout
        transaction(32'h0000007F, 0, 0, 1'b0);          // illegal opcode
        transaction(32'h0080006F, 0, 0, 1'b0);          // JAL
        transaction(32'h0020A023, 0, 4, 1'b1);          // SW, reset during the wait
        transaction(32'h0020A023, 2, 16, 1'b0);         // SW, data timeout

        for (int t = 0; t < 70; t++) begin
            ins  = $urandom;
            kind = $urandom_range(0, 9);
            case (kind)
                0, 9: begin
                    r = $urandom_range(0, 2);
                    ins[6:0] = 7'h33;
                    ins[31:25] = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'h01;
                end
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23;
                4: ins[6:0] = 7'h37;
                5, 6: ins[6:0] = 7'h63;
                7: ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h0F;
                default: ins = 32'h0080006F;
            endcase
            r  = $urandom_range(0, 11);
            di = (r < 8) ? r % 4 : (r == 8) ? WAIT_MAX : (r == 9) ? WAIT_MAX + 1 : 1;
            r  = $urandom_range(0, 11);
            dd = (r < 9) ? r % 5 : (r == 9) ? WAIT_MAX : (r == 10) ? WAIT_MAX + 1 : 2;
            abort = (kind == 3) && ($urandom_range(0, 3) == 0) && (dd <= WAIT_MAX);
            transaction(ins, di, dd, abort);
        end

        repeat (3) @(posedge clk);
        foreach (q[i]) begin
            @(negedge clk);
            expv = exp_out(q[i].st, q[i].ins, q[i].cause);
            vectors++;
            assert (state_o === q[i].st) else begin
                miscompares++;
                $error("FAIL state step=%0d observed=%0d expected=%0d", i, state_o, q[i].st);
            end
            vectors++;
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL outputs step=%0d state=%0d observed=%h expected=%h", i, q[i].st, obs, expv);
            end
            instruction = q[i].ins;
            imem_ready  = q[i].im;
            dmem_ready  = q[i].dm;
            rst         = q[i].rs;
        end
        @(negedge clk);
        vectors++;
        assert (state_o === 4'd0) else begin
            miscompares++;
            $error("FAIL final_state observed=%0d expected=0", state_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
